wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_UNITS execution units that present completed results.
- Selects one done unit per cycle by rotating round-robin priority, or, in in-order mode, only the unit holding the next expected instruction ID.
- Registers the winner onto the register-file writeback port and returns a one-cycle accepted pulse to that unit.
- Sits between unit result outputs and the register file / ID generator completion inputs.

---
 rtl/wb_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// NUM_UNITS execution units that hold completed results.
//
// A unit is granted either by rotating round-robin priority, or (inorder=1)
// only if its instruction ID matches expected_id. The winner is registered
// onto the rf_* port one cycle after the grant, and that unit gets a one-cycle
// unit_accepted pulse in the same cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inorder               1 = only the unit holding expected_id may win
//   flush, flush_id       reload expected_id; no grant in the flush cycle
//   unit_done[i]          unit i holds a valid result
//   unit_rd               packed result data, XLEN bits per unit
//   unit_rd_addr          packed destination register, 5 bits per unit
//   unit_id               packed instruction ID, ID_W bits per unit
//   unit_accepted[i]      one-cycle pulse, unit i's result was written
//   rf_valid_write        register-file write enable
//   rf_rd_addr/data/id    write address, data and instruction ID
//   instruction_complete  copy of rf_valid_write for the ID generator
module wb_port_arbiter #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ID_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inorder,
  input  logic                        flush,
  input  logic [ID_W-1:0]             flush_id,
  input  logic [NUM_UNITS-1:0]        unit_done,
  input  logic [NUM_UNITS*XLEN-1:0]   unit_rd,
  input  logic [NUM_UNITS*5-1:0]      unit_rd_addr,
  input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
  output logic [NUM_UNITS-1:0]        unit_accepted,
  output logic                        rf_valid_write,
  output logic [4:0]                  rf_rd_addr,
  output logic [XLEN-1:0]             rf_rd_data,
  output logic [ID_W-1:0]             rf_id,
  output logic                        instruction_complete
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PTR_W  = $clog2(NUM_UNITS);
  localparam int unsigned SCAN_W = PTR_W + 1;

  // Arbitration state
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] last_grant;
  logic             last_grant_valid;
  logic [ID_W-1:0]  expected_id;

  // Next-state values
  logic [PTR_W-1:0] rr_ptr_next;
  logic [ID_W-1:0]  expected_id_next;

  // Per-unit views of the packed request buses
  logic [XLEN-1:0]   rd_arr      [NUM_UNITS];
  logic [ADDR_W-1:0] rd_addr_arr [NUM_UNITS];
  logic [ID_W-1:0]   id_arr      [NUM_UNITS];
  logic [NUM_UNITS-1:0] eligible;

  // Selection result for this cycle
  logic              grant_valid;
  logic [PTR_W-1:0]  grant_idx;
  logic [SCAN_W-1:0] scan_idx;

  // Unpack request slices and qualify each unit. The unit accepted last cycle
  // is masked because it is still showing the result that was just written.
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign rd_arr[i]      = unit_rd[i*XLEN +: XLEN];
    assign rd_addr_arr[i] = unit_rd_addr[i*ADDR_W +: ADDR_W];
    assign id_arr[i]      = unit_id[i*ID_W +: ID_W];
    assign eligible[i]    = unit_done[i]
                          && !(last_grant_valid && (last_grant == PTR_W'(i)))
                          && !flush
                          && (!inorder || (id_arr[i] == expected_id));
  end

  // Round-robin scan starting at rr_ptr; first eligible unit wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      scan_idx = SCAN_W'(rr_ptr) + SCAN_W'(k);
      if (scan_idx >= SCAN_W'(NUM_UNITS)) begin
        scan_idx = scan_idx - SCAN_W'(NUM_UNITS);
      end
      if (!grant_valid && eligible[scan_idx[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Pointer and expected-ID update; flush overrides the ID
  always_comb begin
    rr_ptr_next      = rr_ptr;
    expected_id_next = expected_id;
    if (grant_valid) begin
      rr_ptr_next      = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0
                                                              : grant_idx + PTR_W'(1);
      expected_id_next = id_arr[grant_idx] + ID_W'(1);
    end
    if (flush) begin
      expected_id_next = flush_id;
    end
  end

  // State and registered writeback port
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr               <= '0;
      last_grant           <= '0;
      last_grant_valid     <= 1'b0;
      expected_id          <= '0;
      unit_accepted        <= '0;
      rf_valid_write       <= 1'b0;
      rf_rd_addr           <= '0;
      rf_rd_data           <= '0;
      rf_id                <= '0;
      instruction_complete <= 1'b0;
    end else begin
      rr_ptr               <= rr_ptr_next;
      expected_id          <= expected_id_next;
      last_grant_valid     <= grant_valid;
      rf_valid_write       <= grant_valid;
      instruction_complete <= grant_valid;
      if (grant_valid) begin
        last_grant    <= grant_idx;
        unit_accepted <= NUM_UNITS'(1) << grant_idx;
        rf_rd_addr    <= rd_addr_arr[grant_idx];
        rf_rd_data    <= rd_arr[grant_idx];
        rf_id         <= id_arr[grant_idx];
      end else begin
        unit_accepted <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a cycle-level model predicts every
// output; directed scenarios add hand-computed expectations.
module tb_wb_port_arbiter;

  localparam int NU   = 4;
  localparam int XL   = 32;
  localparam int IDW  = 3;
  localparam int IDN  = 1 << IDW;

  typedef struct packed {
    logic [31:0] rd;
    logic [4:0]  addr;
    logic [2:0]  id;
  } res_t;

  logic              clk;
  logic              rst;
  logic              inorder;
  logic              flush;
  logic [IDW-1:0]    flush_id;
  logic [NU-1:0]     unit_done;
  logic [NU*XL-1:0]  unit_rd;
  logic [NU*5-1:0]   unit_rd_addr;
  logic [NU*IDW-1:0] unit_id;
  logic [NU-1:0]     unit_accepted;
  logic              rf_valid_write;
  logic [4:0]        rf_rd_addr;
  logic [XL-1:0]     rf_rd_data;
  logic [IDW-1:0]    rf_id;
  logic              instruction_complete;

  wb_port_arbiter #(.NUM_UNITS(NU), .XLEN(XL), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .inorder(inorder), .flush(flush), .flush_id(flush_id),
    .unit_done(unit_done), .unit_rd(unit_rd), .unit_rd_addr(unit_rd_addr),
    .unit_id(unit_id), .unit_accepted(unit_accepted),
    .rf_valid_write(rf_valid_write), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .rf_id(rf_id),
    .instruction_complete(instruction_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-unit result queues; the head is what the unit presents
  res_t uq[NU][$];

  task automatic present();
    for (int i = 0; i < NU; i++) begin
      if (uq[i].size() > 0) begin
        unit_done[i]               = 1'b1;
        unit_rd[i*XL +: XL]        = uq[i][0].rd;
        unit_rd_addr[i*5 +: 5]     = uq[i][0].addr;
        unit_id[i*IDW +: IDW]      = uq[i][0].id;
      end else begin
        unit_done[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int u, input logic [31:0] rd, input logic [4:0] addr, input logic [2:0] id);
    res_t r;
    r.rd = rd; r.addr = addr; r.id = id;
    uq[u].push_back(r);
  endtask

  // One cycle: wait for the sampling edge, retire accepted results, present next
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      if (unit_accepted[i] && uq[i].size() > 0) void'(uq[i].pop_front());
    end
    present();
  endtask

  task automatic clear_units();
    for (int i = 0; i < NU; i++) uq[i].delete();
    present();
  endtask

  // Behavioural model: which unit writes next, from the arbitration rules
  int          m_ptr, m_exp, m_last, m_g, m_i;
  bit          model_ready = 0;
  logic        e_valid;
  logic [NU-1:0] e_acc;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [2:0]  e_id;

  always @(posedge clk) begin
    if (rst) begin
      e_valid = 0; e_acc = '0; e_addr = '0; e_data = '0; e_id = '0;
      m_ptr = 0; m_exp = 0; m_last = -1;
    end else begin
      m_g = -1;
      if (!flush) begin
        for (int k = 0; k < NU; k++) begin
          m_i = (m_ptr + k) % NU;
          if (m_g < 0 && unit_done[m_i] && m_i != m_last &&
              (!inorder || int'(unit_id[m_i*IDW +: IDW]) == m_exp))
            m_g = m_i;
        end
      end
      m_last = m_g;
      if (m_g >= 0) begin
        e_valid = 1;
        e_acc   = '0;
        e_acc[m_g] = 1'b1;
        e_addr  = unit_rd_addr[m_g*5 +: 5];
        e_data  = unit_rd[m_g*XL +: XL];
        e_id    = unit_id[m_g*IDW +: IDW];
        m_ptr   = (m_g + 1) % NU;
        m_exp   = (int'(e_id) + 1) % IDN;
      end else begin
        e_valid = 0;
        e_acc   = '0;
      end
      if (flush) m_exp = int'(flush_id);
    end
    model_ready = 1;
  end

  // Every-cycle comparison against the model
  logic [NU-1:0] prev_acc = '0;
  always @(negedge clk) begin
    if (model_ready) begin
      check("valid_write", 64'(rf_valid_write), 64'(e_valid));
      check("instr_complete", 64'(instruction_complete), 64'(e_valid));
      check("accepted", 64'(unit_accepted), 64'(e_acc));
      check("rd_addr", 64'(rf_rd_addr), 64'(e_addr));
      check("rd_data", 64'(rf_rd_data), 64'(e_data));
      check("rf_id", 64'(rf_id), 64'(e_id));
      check("no_back_to_back", 64'(prev_acc & unit_accepted), 64'(0));
      prev_acc = unit_accepted;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; inorder = 0; flush = 0; flush_id = '0;
    unit_done = '0; unit_rd = '0; unit_rd_addr = '0; unit_id = '0;
    step(); step();
    rst = 0;

    // Idle after reset
    repeat (5) begin
      step();
      check("idle_valid", 64'(rf_valid_write), 64'(0));
      check("idle_acc", 64'(unit_accepted), 64'(0));
      check("idle_data", 64'(rf_rd_data), 64'(0));
    end

    // Units 0 and 2, round robin
    push(0, 32'hA, 5'd5, 3'd0);
    push(2, 32'hC, 5'd7, 3'd2);
    present();
    step();
    check("t2_valid", 64'(rf_valid_write), 64'(1));
    check("t2_addr0", 64'(rf_rd_addr), 64'(5));
    check("t2_data0", 64'(rf_rd_data), 64'(32'hA));
    check("t2_acc0", 64'(unit_accepted), 64'(4'b0001));
    step();
    check("t2_addr2", 64'(rf_rd_addr), 64'(7));
    check("t2_data2", 64'(rf_rd_data), 64'(32'hC));
    check("t2_acc2", 64'(unit_accepted), 64'(4'b0100));
    step();
    check("t2_idle", 64'(rf_valid_write), 64'(0));
    check("t2_idle_acc", 64'(unit_accepted), 64'(0));
    check("t2_hold", 64'(rf_rd_data), 64'(32'hC));

    // Reset, then all four units continuously busy
    rst = 1;
    clear_units();
    step();
    rst = 0;
    check("t3_reset_valid", 64'(rf_valid_write), 64'(0));
    for (int n = 0; n < 3; n++)
      for (int u = 0; u < NU; u++)
        push(u, 32'(32'h100 * u + n), 5'(u + 4 * n + 1), 3'(n));
    present();
    for (int k = 0; k < 12; k++) begin
      step();
      check("t3_valid", 64'(rf_valid_write), 64'(1));
      check("t3_order", 64'(unit_accepted), 64'(1 << (k % 4)));
      check("t3_data", 64'(rf_rd_data), 64'(32'h100 * (k % 4) + k / 4));
    end
    step();
    check("t3_drain", 64'(rf_valid_write), 64'(0));

    // In-order: expected_id=3 via flush; unit3 id3 before unit1 id4
    flush = 1; inorder = 1; flush_id = 3'd3;
    push(1, 32'h11, 5'd1, 3'd4);
    push(3, 32'h33, 5'd3, 3'd3);
    present();
    step();
    check("t4_flush_nogrant", 64'(rf_valid_write), 64'(0));
    flush = 0;
    step();
    check("t4_first_id", 64'(rf_id), 64'(3));
    check("t4_first_acc", 64'(unit_accepted), 64'(4'b1000));
    step();
    check("t4_second_id", 64'(rf_id), 64'(4));
    check("t4_second_acc", 64'(unit_accepted), 64'(4'b0010));
    // expected_id is now 5: unit0 (id5) must beat unit3 (id6) despite rr order
    push(0, 32'h50, 5'd10, 3'd5);
    push(3, 32'h60, 5'd11, 3'd6);
    present();
    step();
    check("t4_exp5_acc", 64'(unit_accepted), 64'(4'b0001));
    check("t4_exp5_id", 64'(rf_id), 64'(5));
    step();
    check("t4_exp6_id", 64'(rf_id), 64'(6));

    // ID wrap: expected 7 -> 0
    push(0, 32'h70, 5'd12, 3'd7);
    push(2, 32'h80, 5'd13, 3'd0);
    present();
    step();
    check("t5_id7", 64'(rf_id), 64'(7));
    check("t5_acc0", 64'(unit_accepted), 64'(4'b0001));
    step();
    check("t5_wrap_id", 64'(rf_id), 64'(0));
    check("t5_acc2", 64'(unit_accepted), 64'(4'b0100));
    step();
    check("t5_idle", 64'(rf_valid_write), 64'(0));

    // Flush right after a grant; expected_id=1 here
    push(3, 32'h90, 5'd9, 3'd1);
    push(1, 32'h55, 5'd14, 3'd5);
    present();
    step();
    flush = 1; flush_id = 3'd2;
    check("t6_preflush_write", 64'(rf_valid_write), 64'(1));
    check("t6_preflush_id", 64'(rf_id), 64'(1));
    step();
    flush = 0;
    check("t6_flush_nogrant", 64'(rf_valid_write), 64'(0));
    check("t6_flush_hold", 64'(rf_id), 64'(1));
    repeat (4) begin
      step();
      check("t6_deadlock", 64'(rf_valid_write), 64'(0));
    end
    push(2, 32'hA2, 5'd15, 3'd2);
    present();
    step();
    check("t6_match_acc", 64'(unit_accepted), 64'(4'b0100));
    check("t6_match_id", 64'(rf_id), 64'(2));
    flush = 1; flush_id = 3'd5;
    step();
    flush = 0;
    check("t6_flush2", 64'(rf_valid_write), 64'(0));
    step();
    check("t6_unit1_acc", 64'(unit_accepted), 64'(4'b0010));
    check("t6_unit1_data", 64'(rf_rd_data), 64'(32'h55));

    // Reset while a unit is requesting: nothing written
    push(0, 32'hBB, 5'd16, 3'd6);
    present();
    rst = 1;
    step();
    check("t7_rst_valid", 64'(rf_valid_write), 64'(0));
    check("t7_rst_acc", 64'(unit_accepted), 64'(0));
    check("t7_rst_data", 64'(rf_rd_data), 64'(0));
    clear_units();
    rst = 0;
    step();
    check("t7_after_rst", 64'(rf_valid_write), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
